// File: rtl/eight_bit_adder.sv
// rtl/eight_bit_adder.sv - 8-bit ripple-carry adder with registered sum, carry-out and valid
module eight_bit_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             out_valid
);

   logic [WIDTH-1:0] s_next;
   logic             c_last;
   logic             carry;

   // Ripple the carry through one full-adder cell per bit, LSB first, carry-in tied to 0
   always_comb begin
      s_next = '0;
      carry  = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         s_next[i] = a[i] ^ b[i] ^ carry;
         carry     = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
      end
      c_last = carry;
   end

   // Capture the result on accepted operands; hold s/cout otherwise so idle cycles leave the last result visible
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s         <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
      end else if (in_valid) begin
         s         <= s_next;
         cout      <= c_last;
         out_valid <= 1'b1;
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_eight_bit_adder.sv
// tb/tb_eight_bit_adder.sv - self-checking bench for eight_bit_adder
module tb_eight_bit_adder;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] s;
   logic       cout;
   logic       out_valid;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   // reference state: what the registered outputs must show
   logic [7:0] m_s    = 8'h00;
   logic       m_cout = 1'b0;
   logic       m_ov   = 1'b0;

   eight_bit_adder #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .s         (s),
      .cout      (cout),
      .out_valid (out_valid)
   );

   // free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // reference: plain 9-bit sum of accepted operands, cleared by reset at once
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s    <= 8'h00;
         m_cout <= 1'b0;
         m_ov   <= 1'b0;
      end else if (in_valid) begin
         {m_cout, m_s} <= 9'(a) + 9'(b);
         m_ov          <= 1'b1;
      end else begin
         m_ov <= 1'b0;
      end
   end

   // compare the DUT against the reference every cycle, away from the active edge
   always @(negedge clk) begin
      if (cmp_en) begin
         n_checks++;
         if ({out_valid, cout, s} !== {m_ov, m_cout, m_s}) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t got ov=%b cout=%b s=%h exp ov=%b cout=%b s=%h",
                     $time, out_valid, cout, s, m_ov, m_cout, m_s);
         end
      end
   end

   task automatic chk(input string name, input logic [9:0] got, input logic [9:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got {ov,cout,s}=%h exp %h", name, got, exp);
      end
   endtask

   // drive one valid pair just after a falling edge, check one cycle later
   task automatic do_add(input string name, input logic [7:0] ta, input logic [7:0] tb_,
                         input logic [7:0] es, input logic ec);
      a        = ta;
      b        = tb_;
      in_valid = 1'b1;
      @(negedge clk);
      chk(name, {out_valid, cout, s}, {1'b1, ec, es});
   endtask

   // watchdog so the run always ends
   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n    = 1'b1;
      in_valid = 1'b1;
      a        = 8'hDA;
      b        = 8'h65;
      #1;
      rst_n = 1'b0;
      #1;
      chk("reset_no_edge", {out_valid, cout, s}, 10'h000);
      cmp_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("reset_held", {out_valid, cout, s}, 10'h000);

      rst_n = 1'b1;
      @(negedge clk);
      chk("first_after_reset", {out_valid, cout, s}, {1'b1, 1'b1, 8'h3F});

      do_add("da_65", 8'hDA, 8'h65, 8'h3F, 1'b1);
      do_add("9b_6d", 8'h9B, 8'h6D, 8'h08, 1'b1);
      do_add("af_58", 8'hAF, 8'h58, 8'h07, 1'b1);
      do_add("00_00", 8'h00, 8'h00, 8'h00, 1'b0);
      do_add("ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
      do_add("ff_ff", 8'hFF, 8'hFF, 8'hFE, 1'b1);
      do_add("7f_01", 8'h7F, 8'h01, 8'h80, 1'b0);

      // throughput: four back-to-back pairs
      do_add("tp0", 8'h01, 8'h02, 8'h03, 1'b0);
      do_add("tp1", 8'h80, 8'h80, 8'h00, 1'b1);
      do_add("tp2", 8'hC8, 8'h64, 8'h2C, 1'b1);
      do_add("tp3", 8'h55, 8'hAA, 8'hFF, 1'b0);

      // hold: result stays, valid drops, idle operands ignored
      do_add("12_34", 8'h12, 8'h34, 8'h46, 1'b0);
      in_valid = 1'b0;
      a        = 8'hFF;
      b        = 8'hFF;
      @(negedge clk);
      chk("hold", {out_valid, cout, s}, {1'b0, 1'b0, 8'h46});
      @(negedge clk);
      chk("hold2", {out_valid, cout, s}, {1'b0, 1'b0, 8'h46});

      // reset mid-operation with a pending pair
      do_add("pre_rst", 8'hDA, 8'h65, 8'h3F, 1'b1);
      a        = 8'h11;
      b        = 8'h22;
      in_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_reset", {out_valid, cout, s}, 10'h000);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      @(negedge clk);
      chk("pending_dropped", {out_valid, cout, s}, 10'h000);

      // random regression with one async reset pulse
      for (int i = 0; i < 10000; i++) begin
         a        = 8'($urandom);
         b        = 8'($urandom);
         in_valid = 1'($urandom_range(0, 1));
         if (i == 5000) begin
            #2;
            rst_n = 1'b0;
            #1;
            chk("rand_reset", {out_valid, cout, s}, 10'h000);
            @(negedge clk);
            rst_n = 1'b1;
            chk("rand_reset_held", {out_valid, cout, s}, 10'h000);
         end else begin
            @(negedge clk);
         end
      end

      in_valid = 1'b0;
      @(negedge clk);
      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
